countdown_timer: RTL and testbench
==================================

# countdown_timer

Cycle-budget timer on the other end of the clock controller's countdown handshake. It counts `core_clock` rising edges while the core runs in automatic mode. After a user-loaded number of edges it raises `countdown_timed_up`, which forces the core into manual mode. It re-arms when the controller asserts `countdown_reset`, which is high whenever manual mode is active. It sits beside the clock controller in the core clock subsystem, fed by board switches and a load push-button.

## Interface
- `COUNT_WIDTH`, 32: width of the cycle budget and the counter.
- `DEBOUNCE_CYCLES`, 1_000_000: number of `clock_100mhz` cycles the load button must be stable (10 ms).
- `clock_100mhz`  in  1  system clock.
- `reset_button`  in  1  reset, asynchronous, active-low.
- `core_clock`  in  1  core clock from the clock controller; registered in the `clock_100mhz` domain, so no synchronizer is required.
- `countdown_reset`  in  1  high = core in manual mode; holds or re-arms the timer.
- `enable`  in  1  countdown feature switch; 0 freezes counting.
- `load_button`  in  1  raw push-button, active-low; asynchronous to `clock_100mhz`.
- `load_value`  in  COUNT_WIDTH  cycle budget from the switches; captured on a debounced press.
- `countdown_timed_up`  out  1  level; high while the budget is exhausted.
- `remaining`  out  COUNT_WIDTH  core cycles left, for the display.
- `armed`  out  1  high in the ARMED or COUNTING state.

## Operation
- Internal registers: `budget` (shadow of the last loaded value), `remaining`, `core_clock_q` (previous sample of `core_clock`), and the state register.
- Core edge event: `core_clock & ~core_clock_q`.
- States: IDLE, ARMED, COUNTING, EXPIRED.
- Reset values: state IDLE; `budget`, `remaining` and `core_clock_q` = 0; `countdown_timed_up` = 0; `armed` = 0.
- Load pulse (debounced press), accepted in any state:
  - `budget` and `remaining` <= `load_value`; `countdown_timed_up` <= 0.
  - Next state is IDLE if `load_value` == 0 (feature off), otherwise ARMED.
- IDLE: holds all values and never counts.
- ARMED: when `countdown_reset` == 0 and `enable` == 1, go to COUNTING. This is the same cycle-level check; edges arriving in ARMED are not counted.
- COUNTING:
  - `countdown_reset` == 1 gives `remaining` <= `budget` and next state ARMED.
  - Otherwise, an edge event with `enable` == 1 decrements `remaining`.
  - If that decrement takes `remaining` from 1 to 0: `countdown_timed_up` <= 1 on the same edge, next state EXPIRED.
  - `enable` == 0 freezes `remaining` and stays in COUNTING.
- EXPIRED: `countdown_timed_up` holds 1 and `remaining` holds 0. When `countdown_reset` == 1: `remaining` <= `budget`, `countdown_timed_up` <= 0, next state ARMED.
- Priority when events coincide: reset > load pulse > `countdown_reset` > edge event.
- `remaining` never wraps; no decrement occurs at 0.

## Timing
- Edge to decrement latency: 1 `clock_100mhz` cycle after `core_clock` is first sampled high.
- `countdown_timed_up` rises on the same `clock_100mhz` edge that writes `remaining` = 0.
- Maximum `core_clock` rate is 50 MHz (toggle every cycle); every rising edge is counted.
- Load press: 2-FF synchronizer, then `DEBOUNCE_CYCLES` of stable low, then a single 1-cycle pulse. Release must also be stable before another press is accepted.
- Reset mid-operation: asynchronous clear to the reset values; the debouncer restarts.
- `countdown_timed_up` is a glitch-free registered level, safe for the controller's asynchronous posedge use.

## Structure
- Shared package: state encoding (`IDLE`=2'd0, `ARMED`=2'd1, `COUNTING`=2'd2, `EXPIRED`=2'd3) and the default `COUNT_WIDTH`.
- Sub-module `button_debouncer`:
  - Parameter `DEBOUNCE_CYCLES`.
  - Ports: `clock_100mhz`, `reset_button`, `button_n` in, `press_pulse` out.
  - Contents: synchronizer, stability counter, press edge detect.
- The top level holds the FSM, the counter and the core edge detector.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES`=4.
- Load then count:
  - Load 5 with `countdown_reset`=0, `enable`=1, `core_clock` toggling every 2 cycles.
  - Expect `remaining` 5→0 over 5 edges, `countdown_timed_up`=1 one cycle after the 5th edge, state EXPIRED.
- Re-arm:
  - From EXPIRED, assert `countdown_reset` for 3 cycles.
  - Expect `countdown_timed_up`=0 and `remaining`=5, `armed`=1.
  - Deassert and expect counting to restart.
- Interruption:
  - During COUNTING at `remaining`=2, assert `countdown_reset`.
  - Expect `remaining`=5 next cycle, state ARMED, no timed-up pulse.
- Zero load and freeze:
  - Load 0: expect IDLE, `armed`=0, and no timed-up after 100 edges.
  - Load 3 and clear `enable` after 1 edge: expect `remaining` frozen at 2.
- Bounce and simultaneity:
  - Load button chatters with pulses shorter than 4 cycles: expect no load.
  - A valid press coinciding with the final edge: expect load wins, `remaining`=`load_value`, `countdown_timed_up`=0.
- Asynchronous reset:
  - Pull `reset_button` low mid-COUNTING.
  - Expect `remaining`=0, `countdown_timed_up`=0, `armed`=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the core-clock countdown timer.
// Imported by the timer top level and its load-button debouncer.
package countdown_timer_pkg;

  localparam int DEFAULT_COUNT_WIDTH     = 32;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    COUNTING = 2'd2,
    EXPIRED  = 2'd3
  } TimerState;

  // The armed indicator covers both waiting-to-count and actively counting.
  function automatic logic isLiveState(input TimerState state);
    return (state == ARMED) || (state == COUNTING);
  endfunction

endpackage

// File: rtl/countdown_timer_button_debouncer.sv
// Debounces the active-low load push-button and emits a single clock_100mhz pulse per press.
// A level change is accepted only after DEBOUNCE_CYCLES consecutive synchronized samples agree.
module button_debouncer
  import countdown_timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock_100mhz,
  input  logic reset_button,
  input  logic button_n,
  output logic press_pulse
);

  localparam int CountWidth = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CountWidth-1:0] LastCount = CountWidth'(DEBOUNCE_CYCLES - 1);

  logic                  sync1_q;
  logic                  sync2_q;
  logic                  stableLevel_q;
  logic [CountWidth-1:0] stableCount_q;
  logic                  pressPulse_q;

  // The counter only runs while the synchronized level disagrees with the accepted level,
  // so any bounce back to the accepted level restarts the qualification window.
  always_ff @(posedge clock_100mhz or negedge reset_button) begin
    if (!reset_button) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      stableLevel_q <= 1'b1;
      stableCount_q <= '0;
      pressPulse_q  <= 1'b0;
    end else begin
      sync1_q      <= button_n;
      sync2_q      <= sync1_q;
      pressPulse_q <= 1'b0;
      if (sync2_q == stableLevel_q) begin
        stableCount_q <= '0;
      end else if (stableCount_q == LastCount) begin
        stableLevel_q <= sync2_q;
        stableCount_q <= '0;
        pressPulse_q  <= ~sync2_q;
      end else begin
        stableCount_q <= stableCount_q + CountWidth'(1);
      end
    end
  end

  assign press_pulse = pressPulse_q;

endmodule

// File: rtl/countdown_timer.sv
// Cycle-budget timer: counts core_clock rising edges in automatic mode and raises
// countdown_timed_up once the loaded budget is used, re-arming when manual mode is entered.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int COUNT_WIDTH     = DEFAULT_COUNT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                   clock_100mhz,
  input  logic                   reset_button,
  input  logic                   core_clock,
  input  logic                   countdown_reset,
  input  logic                   enable,
  input  logic                   load_button,
  input  logic [COUNT_WIDTH-1:0] load_value,
  output logic                   countdown_timed_up,
  output logic [COUNT_WIDTH-1:0] remaining,
  output logic                   armed
);

  TimerState              state_q, state_d;
  logic [COUNT_WIDTH-1:0] budget_q, budget_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                   timedUp_q, timedUp_d;
  logic                   armed_q;
  logic                   coreClock_q;
  logic                   coreEdge;
  logic                   loadPulse;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) loadDebouncer (
    .clock_100mhz(clock_100mhz),
    .reset_button(reset_button),
    .button_n    (load_button),
    .press_pulse (loadPulse)
  );

  assign coreEdge = core_clock & ~coreClock_q;

  // Priority is load pulse, then countdown_reset, then a core edge.
  always_comb begin
    state_d     = state_q;
    budget_d    = budget_q;
    remaining_d = remaining_q;
    timedUp_d   = timedUp_q;
    if (loadPulse) begin
      budget_d    = load_value;
      remaining_d = load_value;
      timedUp_d   = 1'b0;
      state_d     = (load_value == '0) ? IDLE : ARMED;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        ARMED: begin
          if (!countdown_reset && enable) begin
            state_d = COUNTING;
          end
        end
        COUNTING: begin
          if (countdown_reset) begin
            remaining_d = budget_q;
            state_d     = ARMED;
          end else if (coreEdge && enable && (remaining_q != '0)) begin
            remaining_d = remaining_q - COUNT_WIDTH'(1);
            if (remaining_q == COUNT_WIDTH'(1)) begin
              timedUp_d = 1'b1;
              state_d   = EXPIRED;
            end
          end
        end
        EXPIRED: begin
          if (countdown_reset) begin
            remaining_d = budget_q;
            timedUp_d   = 1'b0;
            state_d     = ARMED;
          end
        end
      endcase
    end
  end

  // All outputs come straight from flops so the controller sees glitch-free levels.
  always_ff @(posedge clock_100mhz or negedge reset_button) begin
    if (!reset_button) begin
      state_q     <= IDLE;
      budget_q    <= '0;
      remaining_q <= '0;
      timedUp_q   <= 1'b0;
      armed_q     <= 1'b0;
      coreClock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      budget_q    <= budget_d;
      remaining_q <= remaining_d;
      timedUp_q   <= timedUp_d;
      armed_q     <= isLiveState(state_d);
      coreClock_q <= core_clock;
    end
  end

  assign countdown_timed_up = timedUp_q;
  assign remaining          = remaining_q;
  assign armed              = armed_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: a behavioural model predicts the outputs after every clock,
// pushes them to a scoreboard queue, and a separate monitor drains it against the DUT.
`timescale 1ns/1ps
module tb_countdown_timer;

  localparam int CW  = 32;
  localparam int DEB = 4;

  logic          clock_100mhz = 1'b0;
  logic          reset_button;
  logic          core_clock;
  logic          countdown_reset;
  logic          enable;
  logic          load_button;
  logic [CW-1:0] load_value;
  logic          countdown_timed_up;
  logic [CW-1:0] remaining;
  logic          armed;

  countdown_timer #(
    .COUNT_WIDTH    (CW),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock_100mhz      (clock_100mhz),
    .reset_button      (reset_button),
    .core_clock        (core_clock),
    .countdown_reset   (countdown_reset),
    .enable            (enable),
    .load_button       (load_button),
    .load_value        (load_value),
    .countdown_timed_up(countdown_timed_up),
    .remaining         (remaining),
    .armed             (armed)
  );

  always #5 clock_100mhz = ~clock_100mhz;

  typedef struct {
    logic [CW-1:0] rem;
    logic          tu;
    logic          arm;
  } Expectation;

  Expectation expQ[$];
  int checks   = 0;
  int failures = 0;

  // Model: the loaded budget, cycles left, the timed-up flag and whether edges are being counted.
  logic [CW-1:0] mBudget;
  logic [CW-1:0] mRemaining;
  bit            mTimedUp;
  bit            mCounting;
  bit            mPrevCore;
  // The button is seen two clocks late; a press is accepted once DEB seen samples agree.
  bit            mSeen1, mSeen2;
  bit            mRunLevel;
  int            mRunLen;
  bit            mAccepted;
  bit            mLoadPending;

  bit            tbCore;

  task automatic checkOutput(input string name, input logic [CW-1:0] actual,
                             input logic [CW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mBudget      = '0;
    mRemaining   = '0;
    mTimedUp     = 1'b0;
    mCounting    = 1'b0;
    mPrevCore    = 1'b0;
    mSeen1       = 1'b1;
    mSeen2       = 1'b1;
    mRunLevel    = 1'b1;
    mRunLen      = 0;
    mAccepted    = 1'b1;
    mLoadPending = 1'b0;
  endtask

  task automatic modelStep(input bit core, input bit cr, input bit en, input bit btn,
                           input logic [CW-1:0] lv);
    bit loadNow;
    bit pulseNext;
    bit edgeNow;
    bit seen;
    loadNow   = mLoadPending;
    pulseNext = 1'b0;
    seen      = mSeen2;
    if (seen == mRunLevel) begin
      if (mRunLen < 1000) mRunLen++;
    end else begin
      mRunLevel = seen;
      mRunLen   = 1;
    end
    if (mRunLen >= DEB && seen != mAccepted) begin
      mAccepted = seen;
      pulseNext = (seen == 1'b0);
    end
    mSeen2    = mSeen1;
    mSeen1    = btn;
    edgeNow   = core && !mPrevCore;
    mPrevCore = core;

    if (loadNow) begin
      mBudget    = lv;
      mRemaining = lv;
      mTimedUp   = 1'b0;
      mCounting  = 1'b0;
    end else if (mTimedUp) begin
      if (cr) begin
        mRemaining = mBudget;
        mTimedUp   = 1'b0;
        mCounting  = 1'b0;
      end
    end else if (mBudget != 0) begin
      if (!mCounting) begin
        if (!cr && en) mCounting = 1'b1;
      end else if (cr) begin
        mRemaining = mBudget;
        mCounting  = 1'b0;
      end else if (edgeNow && en && mRemaining > 0) begin
        mRemaining = mRemaining - 1;
        if (mRemaining == 0) begin
          mTimedUp  = 1'b1;
          mCounting = 1'b0;
        end
      end
    end
    mLoadPending = pulseNext;
  endtask

  // Drives one clock's worth of inputs and queues what the outputs must be after that clock.
  task automatic applyStimulus(input bit rstN, input bit core, input bit cr, input bit en,
                               input bit btn, input logic [CW-1:0] lv);
    Expectation e;
    @(negedge clock_100mhz);
    reset_button    = rstN;
    core_clock      = core;
    countdown_reset = cr;
    enable          = en;
    load_button     = btn;
    load_value      = lv;
    if (!rstN) modelReset();
    else modelStep(core, cr, en, btn, lv);
    e.rem = mRemaining;
    e.tu  = mTimedUp;
    e.arm = (mBudget != 0) && !mTimedUp;
    expQ.push_back(e);
  endtask

  task automatic checkAsyncClear(input string tag);
    #1;
    checkOutput({tag, "_remaining"}, remaining, '0);
    checkOutput({tag, "_timed_up"}, CW'(countdown_timed_up), '0);
    checkOutput({tag, "_armed"}, CW'(armed), '0);
  endtask

  task automatic runCycles(input int n, input int period, input bit cr, input bit en);
    for (int i = 0; i < n; i++) begin
      if (period > 0 && (i % period) == 0) tbCore = ~tbCore;
      applyStimulus(1'b1, tbCore, cr, en, 1'b1, load_value);
    end
  endtask

  task automatic runUntil(input logic [CW-1:0] target, input int period, input int maxCycles);
    for (int i = 0; i < maxCycles && mRemaining != target; i++) begin
      if ((i % period) == 0) tbCore = ~tbCore;
      applyStimulus(1'b1, tbCore, 1'b0, 1'b1, 1'b1, load_value);
    end
  endtask

  task automatic pressButton(input logic [CW-1:0] lv, input bit cr, input bit en);
    repeat (DEB + 4) applyStimulus(1'b1, tbCore, cr, en, 1'b0, lv);
    repeat (DEB + 4) applyStimulus(1'b1, tbCore, cr, en, 1'b1, lv);
  endtask

  // Lines the debounced load pulse up with the core edge that would finish the countdown.
  task automatic coincidentLoad(input logic [CW-1:0] lv);
    if (tbCore) begin
      tbCore = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, lv);
    end
    for (int i = 0; i < 20 && !mLoadPending; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, lv);
    tbCore = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, lv);
    repeat (DEB + 4) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, lv);
  endtask

  initial begin : monitor
    Expectation e;
    forever begin
      @(posedge clock_100mhz);
      #2;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("remaining", remaining, e.rem);
        checkOutput("timed_up", CW'(countdown_timed_up), CW'(e.tu));
        checkOutput("armed", CW'(armed), CW'(e.arm));
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    bit            chatter[18];
    bit            rBtn;
    int            btnHold;
    logic [CW-1:0] rLv;
    reset_button    = 1'b0;
    core_clock      = 1'b0;
    countdown_reset = 1'b0;
    enable          = 1'b1;
    load_button     = 1'b1;
    load_value      = '0;
    tbCore          = 1'b0;
    modelReset();

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    checkAsyncClear("reset_start");
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, '0);

    $display("[TB] load 5 and count to expiry");
    pressButton(5, 1'b0, 1'b1);
    runCycles(30, 2, 1'b0, 1'b1);

    $display("[TB] re-arm from expiry, then restart counting");
    runCycles(3, 2, 1'b1, 1'b1);
    runCycles(6, 2, 1'b0, 1'b1);

    $display("[TB] interrupt counting at remaining 2");
    runUntil(2, 2, 40);
    runCycles(1, 2, 1'b1, 1'b1);
    runCycles(6, 2, 1'b0, 1'b1);

    $display("[TB] zero load then many edges");
    pressButton(0, 1'b0, 1'b1);
    runCycles(200, 1, 1'b0, 1'b1);

    $display("[TB] load 3 and freeze after one edge");
    pressButton(3, 1'b0, 1'b1);
    runUntil(2, 2, 40);
    runCycles(20, 2, 1'b0, 1'b0);

    $display("[TB] chattering button must not load");
    chatter = '{0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    foreach (chatter[i]) applyStimulus(1'b1, tbCore, 1'b0, 1'b1, chatter[i], 9);
    runCycles(6, 0, 1'b0, 1'b1);

    $display("[TB] press coinciding with the final edge");
    pressButton(5, 1'b0, 1'b1);
    runUntil(1, 1, 60);
    coincidentLoad(7);
    runCycles(10, 2, 1'b0, 1'b1);

    $display("[TB] asynchronous reset mid-count");
    runCycles(4, 2, 1'b0, 1'b1);
    applyStimulus(1'b0, tbCore, 1'b0, 1'b1, 1'b1, load_value);
    checkAsyncClear("reset_mid_count");
    applyStimulus(1'b0, tbCore, 1'b0, 1'b1, 1'b1, load_value);
    applyStimulus(1'b1, tbCore, 1'b0, 1'b1, 1'b1, load_value);

    $display("[TB] randomized traffic");
    rBtn    = 1'b1;
    btnHold = 5;
    rLv     = 4;
    for (int i = 0; i < 2500; i++) begin
      if (btnHold == 0) begin
        rBtn    = ~rBtn;
        btnHold = $urandom_range(1, 10);
        if (!rBtn) rLv = CW'($urandom_range(0, 12));
      end
      btnHold--;
      if ($urandom_range(0, 2) == 0) tbCore = ~tbCore;
      applyStimulus(($urandom_range(0, 499) != 0), tbCore, ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 9) != 0), rBtn, rLv);
    end
    repeat (3) applyStimulus(1'b1, tbCore, 1'b0, 1'b1, 1'b1, rLv);

    @(posedge clock_100mhz);
    #4;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
